// File: rtl/reverb_param_bank.sv
// Bank of reverb control words: each channel has a stepped target and a
// live value that slews toward it once per audio sample.
module reverb_param_bank #(
    parameter int              NUM_PARAMS  = 4,
    parameter int              DATA_W      = 24,
    parameter int              SEL_W       = 4,
    parameter logic [DATA_W-1:0] STEP        = 24'h010000,
    parameter logic [DATA_W-1:0] MAX_VALUE   = 24'h7FFFFF,
    parameter logic [DATA_W-1:0] RESET_VALUE = 24'h400000,
    parameter logic [DATA_W-1:0] RAMP_STEP   = 24'h000800,
    parameter bit              RAMP_EN     = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         sample_tick,
    input  logic [SEL_W-1:0]             param_sel,
    input  logic [1:0]                   param_update,
    output logic [NUM_PARAMS*DATA_W-1:0] targets_flat,
    output logic [NUM_PARAMS*DATA_W-1:0] values_flat,
    output logic                         busy,
    output logic                         err_sel
);

    localparam logic [SEL_W:0] NP = (SEL_W+1)'(NUM_PARAMS);

    logic [1:0]        s1_q, s2_q, s3_q;
    logic [DATA_W-1:0] tgt_q [NUM_PARAMS];
    logic [DATA_W-1:0] tgt_d [NUM_PARAMS];
    logic [DATA_W-1:0] val_q [NUM_PARAMS];
    logic [DATA_W-1:0] val_d [NUM_PARAMS];
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              rise_inc, rise_dec, one_evt, sel_ok;

    always_comb begin
        logic [DATA_W:0]   sum;
        logic [DATA_W-1:0] diff;
        sum      = '0;
        diff     = '0;
        rise_inc = s2_q[0] & ~s3_q[0];
        rise_dec = s2_q[1] & ~s3_q[1];
        one_evt  = rise_inc ^ rise_dec;
        sel_ok   = {1'b0, param_sel} < NP;
        err_d    = one_evt & ~sel_ok;
        busy_d   = 1'b0;
        for (int i = 0; i < NUM_PARAMS; i++) begin
            tgt_d[i] = tgt_q[i];
            if (one_evt && sel_ok && param_sel == SEL_W'(i)) begin
                if (rise_inc) begin
                    sum = {1'b0, tgt_q[i]} + {1'b0, STEP};
                    tgt_d[i] = (sum > {1'b0, MAX_VALUE}) ? MAX_VALUE
                                                         : sum[DATA_W-1:0];
                end else begin
                    tgt_d[i] = (tgt_q[i] < STEP) ? '0 : tgt_q[i] - STEP;
                end
            end
            // Slew uses the pre-write target; a new target waits for the next tick.
            val_d[i] = val_q[i];
            if (!RAMP_EN) begin
                val_d[i] = tgt_q[i];
            end else if (sample_tick) begin
                if (tgt_q[i] > val_q[i]) begin
                    diff = tgt_q[i] - val_q[i];
                    val_d[i] = val_q[i] + ((diff > RAMP_STEP) ? RAMP_STEP : diff);
                end else begin
                    diff = val_q[i] - tgt_q[i];
                    val_d[i] = val_q[i] - ((diff > RAMP_STEP) ? RAMP_STEP : diff);
                end
            end
            busy_d = busy_d | (val_d[i] != tgt_d[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
            for (int i = 0; i < NUM_PARAMS; i++) begin
                tgt_q[i] <= RESET_VALUE;
                val_q[i] <= RESET_VALUE;
            end
        end else begin
            s1_q   <= param_update;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            busy_q <= busy_d;
            err_q  <= err_d;
            for (int i = 0; i < NUM_PARAMS; i++) begin
                tgt_q[i] <= tgt_d[i];
                val_q[i] <= val_d[i];
            end
        end
    end

    always_comb begin
        targets_flat = '0;
        values_flat  = '0;
        for (int i = 0; i < NUM_PARAMS; i++) begin
            targets_flat[i*DATA_W +: DATA_W] = tgt_q[i];
            values_flat[i*DATA_W +: DATA_W]  = val_q[i];
        end
    end

    assign busy    = busy_q;
    assign err_sel = err_q;

endmodule

// File: tb/tb_reverb_param_bank.sv
// Self-checking bench for reverb_param_bank: directed table, hand sequences,
// and random traffic against a behavioural model (ramped and unramped builds).
module tb_reverb_param_bank;

    localparam int RV = 24'h400000;
    localparam int ST = 24'h010000;
    localparam int MX = 24'h7FFFFF;
    localparam int RS = 24'h000800;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_tick = 1'b0;
    logic [3:0]  param_sel = '0;
    logic [1:0]  param_update = '0;
    logic [95:0] targets_flat, values_flat, targets0, values0;
    logic        busy, err_sel, busy0, err0;

    reverb_param_bank u_dut (
        .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick),
        .param_sel(param_sel), .param_update(param_update),
        .targets_flat(targets_flat), .values_flat(values_flat),
        .busy(busy), .err_sel(err_sel)
    );

    reverb_param_bank #(.RAMP_EN(1'b0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick),
        .param_sel(param_sel), .param_update(param_update),
        .targets_flat(targets0), .values_flat(values0),
        .busy(busy0), .err_sel(err0)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    int         mt [4];
    int         mv [4];
    int         mv0 [4];
    logic       mb, mb0, merr;
    logic [1:0] lv1, lv2, lv3;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [95:0] pack(input int a [4]);
        logic [95:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[i*24 +: 24] = a[i][23:0];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mt[i] = RV; mv[i] = RV; mv0[i] = RV;
        end
        mb = 0; mb0 = 0; merr = 0;
        lv1 = '0; lv2 = '0; lv3 = '0;
    endtask

    task automatic model_edge();
        logic ri, rd;
        int   d;
        // An event is a level seen high two samples ago but low three samples ago
        ri = lv2[0] & ~lv3[0];
        rd = lv2[1] & ~lv3[1];
        lv3 = lv2; lv2 = lv1; lv1 = param_update;
        for (int i = 0; i < 4; i++) begin
            mv0[i] = mt[i];
            if (sample_tick) begin
                d = mt[i] - mv[i];
                if (d > RS) d = RS;
                if (d < -RS) d = -RS;
                mv[i] = mv[i] + d;
            end
        end
        merr = (ri ^ rd) && (param_sel >= 4);
        if ((ri ^ rd) && param_sel < 4) begin
            d = mt[param_sel] + (ri ? ST : -ST);
            if (d > MX) d = MX;
            if (d < 0) d = 0;
            mt[param_sel] = d;
        end
        mb = 0; mb0 = 0;
        for (int i = 0; i < 4; i++) begin
            if (mv[i] != mt[i]) mb = 1;
            if (mv0[i] != mt[i]) mb0 = 1;
        end
    endtask

    task automatic check_model();
        chk("targets", targets_flat, pack(mt));
        chk("values", values_flat, pack(mv));
        chk("busy", 96'(busy), 96'(mb));
        chk("err_sel", 96'(err_sel), 96'(merr));
        chk("targets0", targets0, pack(mt));
        chk("values0", values0, pack(mv0));
        chk("busy0", 96'(busy0), 96'(mb0));
        chk("err0", 96'(err0), 96'(merr));
    endtask

    task automatic step(input logic [1:0] upd, input logic [3:0] sel, input logic tk);
        @(negedge clk);
        param_update = upd;
        param_sel    = sel;
        sample_tick  = tk;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic ev(input int bitn, input logic [3:0] sel);
        logic [1:0] u;
        u = '0;
        u[bitn] = 1'b1;
        repeat (3) step(u, sel, 1'b0);
        repeat (3) step(2'b00, sel, 1'b0);
    endtask

    function automatic logic [23:0] tch(input int ch);
        return targets_flat[ch*24 +: 24];
    endfunction

    function automatic logic [23:0] vch(input int ch);
        return values_flat[ch*24 +: 24];
    endfunction

    typedef struct {
        logic [1:0]  upd;
        logic [3:0]  sel;
        logic        tick;
        int          n;
        int          ch;
        logic [23:0] tgt;
        logic [23:0] val;
        logic        busy;
        logic        err;
    } vec_t;

    vec_t tbl [14];

    initial begin
        tbl[0]  = '{2'b00, 4'd2, 1'b0, 1,  2, 24'h400000, 24'h400000, 1'b0, 1'b0};
        tbl[1]  = '{2'b01, 4'd2, 1'b0, 2,  2, 24'h400000, 24'h400000, 1'b0, 1'b0};
        tbl[2]  = '{2'b01, 4'd2, 1'b0, 1,  2, 24'h410000, 24'h400000, 1'b1, 1'b0};
        tbl[3]  = '{2'b01, 4'd2, 1'b0, 2,  2, 24'h410000, 24'h400000, 1'b1, 1'b0};
        tbl[4]  = '{2'b00, 4'd2, 1'b0, 4,  2, 24'h410000, 24'h400000, 1'b1, 1'b0};
        tbl[5]  = '{2'b00, 4'd2, 1'b1, 8,  2, 24'h410000, 24'h404000, 1'b1, 1'b0};
        tbl[6]  = '{2'b00, 4'd2, 1'b1, 23, 2, 24'h410000, 24'h40F800, 1'b1, 1'b0};
        tbl[7]  = '{2'b00, 4'd2, 1'b1, 1,  2, 24'h410000, 24'h410000, 1'b0, 1'b0};
        tbl[8]  = '{2'b11, 4'd1, 1'b0, 4,  1, 24'h400000, 24'h400000, 1'b0, 1'b0};
        tbl[9]  = '{2'b00, 4'd1, 1'b0, 4,  1, 24'h400000, 24'h400000, 1'b0, 1'b0};
        tbl[10] = '{2'b01, 4'd5, 1'b0, 2,  0, 24'h400000, 24'h400000, 1'b0, 1'b0};
        tbl[11] = '{2'b01, 4'd5, 1'b0, 1,  0, 24'h400000, 24'h400000, 1'b0, 1'b1};
        tbl[12] = '{2'b01, 4'd5, 1'b0, 1,  0, 24'h400000, 24'h400000, 1'b0, 1'b0};
        tbl[13] = '{2'b00, 4'd5, 1'b0, 4,  0, 24'h400000, 24'h400000, 1'b0, 1'b0};

        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_model();

        // Directed table: update latency, ramp, same-clk inc/dec, bad select
        for (int k = 0; k < 14; k++) begin
            for (int c = 0; c < tbl[k].n; c++) step(tbl[k].upd, tbl[k].sel, tbl[k].tick);
            chk($sformatf("tbl%0d_tgt", k), 96'(tch(tbl[k].ch)), 96'(tbl[k].tgt));
            chk($sformatf("tbl%0d_val", k), 96'(vch(tbl[k].ch)), 96'(tbl[k].val));
            chk($sformatf("tbl%0d_busy", k), 96'(busy), 96'(tbl[k].busy));
            chk($sformatf("tbl%0d_err", k), 96'(err_sel), 96'(tbl[k].err));
        end

        // Target write on a tick edge: ramp still aims at the old target
        step(2'b01, 4'd3, 1'b0);
        step(2'b01, 4'd3, 1'b0);
        step(2'b01, 4'd3, 1'b1);
        chk("tw_tgt", 96'(tch(3)), 96'(24'h410000));
        chk("tw_val", 96'(vch(3)), 96'(24'h400000));
        chk("tw_val0", 96'(values0[72 +: 24]), 96'(24'h400000));
        step(2'b01, 4'd3, 1'b1);
        chk("tw_val_next", 96'(vch(3)), 96'(24'h400800));
        chk("tw_val0_next", 96'(values0[72 +: 24]), 96'(24'h410000));
        repeat (3) step(2'b00, 4'd3, 1'b0);
        repeat (3) step(2'b00, 4'd3, 1'b1);
        chk("rev_pre", 96'(vch(3)), 96'(24'h402000));

        // Reversal mid-ramp
        ev(1, 4'd3);
        ev(1, 4'd3);
        chk("rev_tgt", 96'(tch(3)), 96'(24'h3F0000));
        step(2'b00, 4'd3, 1'b1);
        chk("rev_turn", 96'(vch(3)), 96'(24'h401800));
        repeat (34) step(2'b00, 4'd3, 1'b1);
        chk("rev_near", 96'(vch(3)), 96'(24'h3F0800));
        chk("rev_near_busy", 96'(busy), 96'(1'b1));
        step(2'b00, 4'd3, 1'b1);
        chk("rev_done", 96'(vch(3)), 96'(24'h3F0000));
        chk("rev_done_busy", 96'(busy), 96'(1'b0));

        // Saturation at both ends
        repeat (63) ev(0, 4'd0);
        chk("sat_7f", 96'(tch(0)), 96'(24'h7F0000));
        ev(0, 4'd0);
        chk("sat_max", 96'(tch(0)), 96'(24'h7FFFFF));
        ev(0, 4'd0);
        chk("sat_hold", 96'(tch(0)), 96'(24'h7FFFFF));
        repeat (64) ev(1, 4'd1);
        chk("sat_zero", 96'(tch(1)), 96'(24'h000000));
        ev(1, 4'd1);
        chk("sat_zero_hold", 96'(tch(1)), 96'(24'h000000));
        repeat (127) ev(1, 4'd0);
        chk("sat_ffff", 96'(tch(0)), 96'(24'h00FFFF));
        ev(1, 4'd0);
        chk("sat_floor", 96'(tch(0)), 96'(24'h000000));

        // Asynchronous reset mid-ramp
        ev(0, 4'd2);
        repeat (3) step(2'b00, 4'd2, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_tgt", targets_flat, {4{24'h400000}});
        chk("ar_val", values_flat, {4{24'h400000}});
        chk("ar_busy", 96'(busy), 96'(1'b0));
        model_reset();
        check_model();
        @(negedge clk);
        reset_n = 1'b1;

        // Random traffic against the model
        begin
            logic [1:0] u;
            u = '0;
            for (int c = 0; c < 800; c++) begin
                if ($urandom_range(0, 3) == 0) u = 2'($urandom_range(0, 3));
                step(u, 4'($urandom_range(0, 5)), ($urandom_range(0, 2) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
